// File: rtl/axppa_operand_sequencer_if.sv
// Operand-in / sum-out valid-ready bundle for the approximate-adder operand sequencer.
interface axppa_operand_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/axppa_operand_sequencer.sv
// Assembles A/B/C operand triplets for a three-operand adder, waits a settle
// time, captures the adder sum and offers it on a valid/ready output.
module axppa_operand_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    axppa_operand_sequencer_if.slave          bus,
    output logic [WIDTH-1:0]                  a_op,
    output logic [WIDTH-1:0]                  b_op,
    output logic [WIDTH-1:0]                  c_op,
    input  logic [WIDTH-1:0]                  sum_in,
    output logic                              busy,
    output logic [7:0]                        triplet_count
);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             in_ready_c;
    logic             in_hs;
    logic             out_hs;
    logic             capture;

    assign in_hs   = bus.in_valid && in_ready_c;
    assign out_hs  = out_valid_q && bus.out_ready;
    assign capture = (state == SETTLE) && (settle_cnt == 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready_c = 1'b1;
                if (in_hs) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready_c = 1'b1;
                if (in_hs) state_next = LOAD_C;
            end
            LOAD_C: begin
                in_ready_c = 1'b1;
                if (in_hs) state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd1) state_next = HOLD;
            end
            HOLD: begin
                if (out_hs) state_next = LOAD_A;
            end
            default: state_next = LOAD_A;
        endcase
        // clear overrides any transition, including a pending output handshake
        if (clear) state_next = LOAD_A;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_op          <= '0;
            b_op          <= '0;
            c_op          <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            settle_cnt    <= 4'd0;
            triplet_count <= 8'd0;
        end else if (clear) begin
            a_op        <= '0;
            b_op        <= '0;
            c_op        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            settle_cnt  <= 4'd0;
        end else begin
            case (state)
                LOAD_A: if (in_hs) a_op <= bus.in_data;
                LOAD_B: if (in_hs) b_op <= bus.in_data;
                LOAD_C: begin
                    if (in_hs) begin
                        c_op       <= bus.in_data;
                        settle_cnt <= 4'(SETTLE_CYCLES);
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (capture) begin
                        out_data_q  <= sum_in;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        out_valid_q   <= 1'b0;
                        triplet_count <= triplet_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state != LOAD_A);

endmodule

// File: tb/tb_axppa_operand_sequencer.sv
// Directed bench for axppa_operand_sequencer: one instance with SETTLE_CYCLES=1,
// one with SETTLE_CYCLES=4; sum_in comes from an exact mod-2^16 adder model.
module tb_axppa_operand_sequencer;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] a1, b1, c1, sum1;
    logic [15:0] a4, b4, c4, sum4;
    logic        busy1, busy4;
    logic [7:0]  cnt1, cnt4;
    int          ncmp;
    int          nerr;

    axppa_operand_sequencer_if #(.WIDTH(16)) bus1 ();
    axppa_operand_sequencer_if #(.WIDTH(16)) bus4 ();

    assign sum1 = a1 + b1 + c1;
    assign sum4 = a4 + b4 + c4;

    axppa_operand_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus1),
        .a_op(a1), .b_op(b1), .c_op(c1), .sum_in(sum1),
        .busy(busy1), .triplet_count(cnt1)
    );

    axppa_operand_sequencer #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus4),
        .a_op(a4), .b_op(b4), .c_op(c4), .sum_in(sum4),
        .busy(busy4), .triplet_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = w;
        while (!bus1.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_ready_timeout", {31'd0, bus1.in_ready}, 32'd1);
        tick();
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus1.out_valid && n < 10) begin
            tick();
            n++;
        end
        check(tag, {31'd0, bus1.out_valid}, 32'd1);
    endtask

    task automatic trip(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [15:0] exp_sum);
        send_word(a);
        send_word(b);
        send_word(c);
        wait_out("trip_valid_timeout");
        check("trip_data", {16'd0, bus1.out_data}, {16'd0, exp_sum});
        tick();
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        reset = 1'b0;
        clear = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = 16'h0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = 16'h0; bus4.out_ready = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_count", {24'd0, cnt1}, 32'd0);
        check("rst_a_op", {16'd0, a1}, 32'd0);
        check("rst_out_data", {16'd0, bus1.out_data}, 32'd0);
        check("rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        reset = 1'b1;
        tick();

        // basic triplet 1+2+3, settle 1
        send_word(16'h0001);
        send_word(16'h0002);
        send_word(16'h0003);
        check("basic_settle_valid", {31'd0, bus1.out_valid}, 32'd0);
        check("basic_settle_in_ready", {31'd0, bus1.in_ready}, 32'd0);
        check("basic_settle_busy", {31'd0, busy1}, 32'd1);
        tick();
        check("basic_out_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("basic_out_data", {16'd0, bus1.out_data}, 32'h0006);
        check("basic_count_pre", {24'd0, cnt1}, 32'd0);
        tick();
        check("basic_out_valid_drop", {31'd0, bus1.out_valid}, 32'd0);
        check("basic_count", {24'd0, cnt1}, 32'd1);
        check("basic_in_ready_again", {31'd0, bus1.in_ready}, 32'd1);

        // wrap with settle 4 on second instance
        bus4.in_valid = 1'b1;
        bus4.in_data = 16'hFFFF; tick();
        bus4.in_data = 16'hFFFF; tick();
        bus4.in_data = 16'h0003; tick();
        bus4.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("wrap_early_valid", {31'd0, bus4.out_valid}, 32'd0);
        end
        tick();
        check("wrap_valid_e4", {31'd0, bus4.out_valid}, 32'd1);
        check("wrap_data", {16'd0, bus4.out_data}, 32'h0001);
        tick();
        check("wrap_count", {24'd0, cnt4}, 32'd1);

        // input gaps 1,0,0,1,0,1 then output backpressure
        bus1.out_ready = 1'b0;
        bus1.in_valid = 1'b1; bus1.in_data = 16'h1234; tick();
        bus1.in_valid = 1'b0; bus1.in_data = 16'hDEAD; tick();
        tick();
        bus1.in_valid = 1'b1; bus1.in_data = 16'h1111; tick();
        bus1.in_valid = 1'b0; bus1.in_data = 16'hBEEF; tick();
        bus1.in_valid = 1'b1; bus1.in_data = 16'h0F0F; tick();
        bus1.in_valid = 1'b0;
        check("gap_a", {16'd0, a1}, 32'h1234);
        check("gap_b", {16'd0, b1}, 32'h1111);
        check("gap_c", {16'd0, c1}, 32'h0F0F);
        tick();
        bus1.in_valid = 1'b1; bus1.in_data = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, bus1.out_valid}, 32'd1);
            check("bp_out_data", {16'd0, bus1.out_data}, 32'h3254);
            check("bp_a", {16'd0, a1}, 32'h1234);
            check("bp_c", {16'd0, c1}, 32'h0F0F);
            check("bp_in_ready", {31'd0, bus1.in_ready}, 32'd0);
            tick();
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        tick();
        check("bp_count", {24'd0, cnt1}, 32'd2);
        check("bp_valid_drop", {31'd0, bus1.out_valid}, 32'd0);

        // clear after B, with a coincident C handshake attempt
        send_word(16'h0AAA);
        send_word(16'h0BBB);
        clear = 1'b1;
        bus1.in_valid = 1'b1; bus1.in_data = 16'h0CCC;
        tick();
        clear = 1'b0;
        bus1.in_valid = 1'b0;
        check("clr_busy", {31'd0, busy1}, 32'd0);
        check("clr_a", {16'd0, a1}, 32'd0);
        check("clr_b", {16'd0, b1}, 32'd0);
        check("clr_c", {16'd0, c1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_no_out", {31'd0, bus1.out_valid}, 32'd0);
        end
        check("clr_count", {24'd0, cnt1}, 32'd2);
        trip(16'h0100, 16'h0200, 16'h0300, 16'h0600);
        check("clr_next_count", {24'd0, cnt1}, 32'd3);

        // clear beats out_ready in HOLD
        bus1.out_ready = 1'b0;
        send_word(16'h0001);
        send_word(16'h0001);
        send_word(16'h0001);
        tick();
        check("hclr_valid", {31'd0, bus1.out_valid}, 32'd1);
        clear = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        clear = 1'b0;
        check("hclr_valid_drop", {31'd0, bus1.out_valid}, 32'd0);
        check("hclr_count", {24'd0, cnt1}, 32'd3);
        check("hclr_out_data", {16'd0, bus1.out_data}, 32'd0);
        check("hclr_busy", {31'd0, busy1}, 32'd0);

        // async reset during SETTLE
        send_word(16'h0007);
        send_word(16'h0008);
        send_word(16'h0009);
        check("rmid_in_settle", {31'd0, busy1}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rmid_busy", {31'd0, busy1}, 32'd0);
        check("rmid_a", {16'd0, a1}, 32'd0);
        check("rmid_c", {16'd0, c1}, 32'd0);
        check("rmid_count", {24'd0, cnt1}, 32'd0);
        check("rmid_valid", {31'd0, bus1.out_valid}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rmid_no_out", {31'd0, bus1.out_valid}, 32'd0);
        end
        check("rmid_count_after", {24'd0, cnt1}, 32'd0);

        // 256 triplets: a=i, b=0x8000, c=0x8000+i -> sum = 2i mod 2^16
        for (int i = 0; i < 256; i++) begin
            trip(16'(i), 16'h8000, 16'(16'h8000 + i), 16'(2 * i));
            if (i == 254) check("cwrap_255", {24'd0, cnt1}, 32'hFF);
        end
        check("cwrap_256", {24'd0, cnt1}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/axppa_operand_sequencer.md
# axppa_operand_sequencer

Upstream operand stage for the 16-bit three-operand approximate prefix adders (Kogge-Stone and siblings). It accepts a serial stream of operand words over a valid/ready handshake and assembles them into A/B/C triplets. Each triplet is held stable on registered outputs that drive the adder's `a_input`/`b_input`/`c_input`. The block waits a programmable settle time, samples the adder's combinational `sum_output`, and presents the result on a valid/ready output port.

## Interface

Parameters:
- `WIDTH`, 16, operand/sum width; must match the adder.
- `SETTLE_CYCLES`, 1, cycles from C-operand acceptance to sum capture; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; low clears all state immediately.
- `clear`  in  1  synchronous abort of the current triplet.
- `in_data`  in  WIDTH  operand word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept an operand word.
- `a_op`, `b_op`, `c_op`  out  WIDTH each  registered operands; connect to adder `a_input`/`b_input`/`c_input`.
- `sum_in`  in  WIDTH  adder `sum_output`.
- `out_data`  out  WIDTH  captured sum.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  high whenever state ≠ LOAD_A.
- `triplet_count`  out  8  count of completed output handshakes; wraps 255→0.

## Operation

- FSM states: LOAD_A, LOAD_B, LOAD_C, SETTLE, HOLD.
- An input handshake is `in_valid && in_ready`.
  - LOAD_A: handshake writes `a_op`, goes to LOAD_B.
  - LOAD_B: handshake writes `b_op`, goes to LOAD_C.
  - LOAD_C: handshake writes `c_op`, loads the settle counter with `SETTLE_CYCLES`, goes to SETTLE.
- `in_ready` is combinational: 1 in the LOAD_A/B/C states, 0 in SETTLE and HOLD.
- Gaps in `in_valid` are legal. The FSM waits in the current LOAD state with no timeout.
- SETTLE: the counter decrements once per cycle.
  - On the edge where the counter equals 1, `sum_in` is registered into `out_data`, `out_valid` is set, and the FSM goes to HOLD.
- HOLD: `out_data` and `out_valid` are held stable until `out_ready` is high.
  - On `out_valid && out_ready`: clear `out_valid`, increment `triplet_count`, go to LOAD_A.
  - There is no overlap: the next A is not accepted in the handshake cycle.
- `a_op`/`b_op`/`c_op` hold their values through SETTLE and HOLD. Each is overwritten only by its own next load.
- Arithmetic: the block does no arithmetic. `out_data` is a bit-exact copy of `sum_in`. Carry-out is discarded by the adder, so the result is mod 2^WIDTH.
- `clear` (synchronous, highest priority after reset):
  - In any state, at the next edge the FSM goes to LOAD_A.
  - `a_op`, `b_op`, `c_op` and `out_data` go to 0, and `out_valid` goes to 0.
  - `triplet_count` is unchanged.
  - Any handshake in the same cycle is ignored.

## Timing

- Reset (`reset` low, asynchronous):
  - State LOAD_A.
  - `a_op`, `b_op`, `c_op`, `out_data` = 0.
  - `out_valid` = 0, `busy` = 0, `triplet_count` = 0.
  - `in_ready` reads 1, but no handshake is accepted while `reset` is low.
- Deassertion of `reset` takes effect at the first rising edge after `reset` goes high.
- Latency: with the C handshake at edge E0, `out_valid` rises after edge E`SETTLE_CYCLES`. With the default of 1, `out_valid` rises one cycle after C is accepted.
- Minimum triplet period with `out_ready` tied high and back-to-back inputs: 3 + `SETTLE_CYCLES` + 1 cycles.
- Reset asserted mid-SETTLE or mid-HOLD: the result is lost, no output handshake occurs, and the count is not incremented.
- `clear` together with `out_ready` in HOLD: `clear` wins. No handshake occurs and the count is unchanged.

## Test plan

For all scenarios, the bench drives `sum_in` from an exact model, (`a_op`+`b_op`+`c_op`) mod 2^16, unless the real adder is instantiated.

- Basic triplet: send 0x0001, 0x0002, 0x0003 with `out_ready`=1 → `out_data`=0x0006 and `out_valid` high one cycle after C acceptance; `triplet_count`=1; `in_ready` high again the next cycle.
- Wrap: send 0xFFFF, 0xFFFF, 0x0003 with `SETTLE_CYCLES`=4 → `out_valid` rises 4 cycles after C acceptance; `out_data`=0x0001.
- Backpressure and gaps:
  - `in_valid` toggles 1,0,0,1,0,1 across the three words → correct triplet loaded.
  - `out_ready` low for 5 cycles in HOLD → `out_valid`, `out_data` and `a_op`/`b_op`/`c_op` stable; `in_ready`=0 throughout.
- Clear: assert `clear` after B is accepted → next cycle state LOAD_A, `a_op`=`b_op`=0, no output; the next triplet computes correctly.
- Reset mid-operation: pulse `reset` low during SETTLE → all outputs return to reset values asynchronously; no `out_valid` pulse; `triplet_count`=0.
- Counter wrap: complete 256 triplets → `triplet_count` reads 0xFF after 255 and 0x00 after 256.
